sobel_feeder: RTL

SOBEL_FEEDER -- requirements
Module: sobel_feeder

---
 rtl/sobel_feeder_pkg.sv | 16 +
 rtl/sobel_line_buffer.sv | 50 +++++
 rtl/sobel_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_feeder_pkg.sv
// Shared parameters for the Sobel feeder slice.
//   PIXEL_WIDTH_IN  : width of the raster pixel entering the feeder
//   PIXEL_WIDTH_OUT : width of the window pixel handed to the window builder
//   ROW_GAP_CYCLES  : idle cycles inserted between window rows
//   zext_px()       : zero-extends an input pixel to the output width
package sobel_feeder_pkg;

    localparam int PIXEL_WIDTH_IN  = 8;
    localparam int PIXEL_WIDTH_OUT = 10;
    localparam int ROW_GAP_CYCLES  = 2;

    function automatic logic [PIXEL_WIDTH_OUT-1:0] zext_px(input logic [PIXEL_WIDTH_IN-1:0] px);
        return {{(PIXEL_WIDTH_OUT-PIXEL_WIDTH_IN){1'b0}}, px};
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store feeding the top and middle rows of the Sobel window.
// Ports:
//   clk_i     : clock
//   addr      : column index shared by the read and both write paths
//   top_px    : line 0 (oldest row) at addr
//   mid_px    : line 1 (newer row) at addr
//   fill_en   : write fill_px into the line chosen by fill_line
//   fill_line : 0 = line 0, 1 = line 1
//   fill_px   : pixel written during the initial two-row fill
//   shift_en  : move line 1 into line 0 and shift_px into line 1 at addr
//   shift_px  : newest pixel of the column
// Contents are deliberately not reset; the fill pass overwrites every entry
// before anything is read.
module sobel_line_buffer
    import sobel_feeder_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    localparam int AW = $clog2(IMG_WIDTH)
) (
    input  logic                      clk_i,
    input  logic [AW-1:0]             addr,
    output logic [PIXEL_WIDTH_IN-1:0] top_px,
    output logic [PIXEL_WIDTH_IN-1:0] mid_px,
    input  logic                      fill_en,
    input  logic                      fill_line,
    input  logic [PIXEL_WIDTH_IN-1:0] fill_px,
    input  logic                      shift_en,
    input  logic [PIXEL_WIDTH_IN-1:0] shift_px
);

    logic [PIXEL_WIDTH_IN-1:0] line0 [IMG_WIDTH];
    logic [PIXEL_WIDTH_IN-1:0] line1 [IMG_WIDTH];

    assign top_px = line0[addr];
    assign mid_px = line1[addr];

    always_ff @(posedge clk_i) begin
        if (shift_en) begin
            line0[addr] <= line1[addr];
            line1[addr] <= shift_px;
        end else if (fill_en) begin
            if (fill_line) begin
                line1[addr] <= fill_px;
            end else begin
                line0[addr] <= fill_px;
            end
        end
    end

endmodule

// File: rtl/sobel_feeder.sv
// Turns a raster pixel stream into column triplets (top, middle, bottom) for
// a 3x3 Sobel window builder. Rows 0 and 1 only fill the line buffers; from
// row 2 on, every accepted pixel produces three strobed output pixels.
// Ports:
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   frame_start_i   : starts a frame from IDLE or DONE
//   in_px_i         : raster-order grayscale pixel
//   in_valid_i      : in_px_i valid
//   in_ready_o      : pixel accepted this cycle when also valid
//   out_px_o        : window pixel, zero-extended
//   px_rdy_o        : one-cycle strobe qualifying out_px_o
//   start_sobel_o   : high across a whole window row
//   frame_done_o    : one-cycle pulse when the frame's last column is out
//
// state    | meaning
// IDLE     | waiting for frame_start_i after reset
// FILL     | loading rows 0 and 1 into the line buffers
// ACCEPT   | waiting for the next pixel of a window row
// EMIT_TOP | registering line 0 pixel of the column
// EMIT_MID | registering line 1 pixel of the column
// EMIT_BOT | registering the latched pixel, shifting the line buffers
// ROW_GAP  | start_sobel_o held low between window rows
// DONE     | frame complete, waiting for frame_start_i
module sobel_feeder
    import sobel_feeder_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       frame_start_i,
    input  logic [7:0]                 in_px_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [PIXEL_WIDTH_OUT-1:0] out_px_o,
    output logic                       px_rdy_o,
    output logic                       start_sobel_o,
    output logic                       frame_done_o
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    GAP_LOAD = 2'(ROW_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ACCEPT,
        EMIT_TOP,
        EMIT_MID,
        EMIT_BOT,
        ROW_GAP,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [1:0]        gap_cnt;
    logic [7:0]        held_px;
    logic [7:0]        top_px;
    logic [7:0]        mid_px;
    logic              xfer;
    logic              row_end;
    logic              last_row;
    logic              frame_go;
    logic              advance;

    assign in_ready_o = (state == FILL) || (state == ACCEPT);
    assign xfer       = in_valid_i && in_ready_o;
    assign row_end    = (x == X_LAST);
    assign last_row   = (y == Y_LAST);
    assign frame_go   = ((state == IDLE) || (state == DONE)) && frame_start_i;
    // EMIT_BOT closes the column of the pixel accepted in ACCEPT, so the
    // counters move there rather than at the handshake; lb addressing stays
    // on the current column through all three emit cycles.
    assign advance    = ((state == FILL) && xfer) || (state == EMIT_BOT);

    sobel_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .addr      (x),
        .top_px    (top_px),
        .mid_px    (mid_px),
        .fill_en   ((state == FILL) && xfer),
        .fill_line (y[0]),
        .fill_px   (in_px_i),
        .shift_en  (state == EMIT_BOT),
        .shift_px  (held_px)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (frame_start_i) state_nxt = FILL;
            end
            FILL: begin
                if (xfer && row_end && (y == YW'(1))) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                if (xfer) state_nxt = EMIT_TOP;
            end
            EMIT_TOP: state_nxt = EMIT_MID;
            EMIT_MID: state_nxt = EMIT_BOT;
            EMIT_BOT: begin
                if (!row_end)     state_nxt = ACCEPT;
                else if (last_row) state_nxt = DONE;
                else              state_nxt = ROW_GAP;
            end
            ROW_GAP: begin
                if (gap_cnt == 2'd0) state_nxt = ACCEPT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            x <= '0;
            y <= '0;
        end else if (frame_go) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (row_end) begin
                x <= '0;
                y <= last_row ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            gap_cnt <= '0;
            held_px <= '0;
        end else begin
            if (state == EMIT_BOT) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ROW_GAP) && (gap_cnt != 2'd0)) begin
                gap_cnt <= gap_cnt - 2'd1;
            end
            if ((state == ACCEPT) && xfer) begin
                held_px <= in_px_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            out_px_o      <= '0;
            px_rdy_o      <= 1'b0;
            start_sobel_o <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            px_rdy_o     <= (state == EMIT_TOP) || (state == EMIT_MID) || (state == EMIT_BOT);
            frame_done_o <= (state == EMIT_BOT) && (state_nxt == DONE);
            case (state)
                EMIT_TOP: out_px_o <= zext_px(top_px);
                EMIT_MID: out_px_o <= zext_px(mid_px);
                EMIT_BOT: out_px_o <= zext_px(held_px);
                default:  out_px_o <= out_px_o;
            endcase
            // Set with the first top pixel of the row; cleared only once the
            // row's final strobe (visible during the first ROW_GAP/DONE cycle)
            // has been presented.
            if (state == EMIT_TOP) begin
                start_sobel_o <= 1'b1;
            end else if ((state == ROW_GAP) || (state == DONE) || (state == IDLE)) begin
                start_sobel_o <= 1'b0;
            end
        end
    end

endmodule
